// File: rtl/qft_cphase_sequencer.sv
// QFT gate-order sequencer: walks Hadamard / controlled-phase / bit-reversal swap
// descriptors for NUM_QUBITS qubits and hands them downstream over valid/ready.
module qft_cphase_sequencer #(
  parameter int NUM_QUBITS = 4,
  parameter int TOTAL_BITS = 16,
  parameter int FRAC_BITS  = 13,
  parameter int PI_FIXED   = 25736,
  parameter int QW         = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1,
  parameter int IDX_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         op_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         op_valid,
  output logic [1:0]                   op_code,
  output logic [QW-1:0]                op_ctrl,
  output logic [QW-1:0]                op_tgt,
  output logic signed [TOTAL_BITS-1:0] op_theta,
  output logic [IDX_W-1:0]             op_index
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HAD  = 3'd1,
    S_CPH  = 3'd2,
    S_SWP  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [1:0] OP_HAD = 2'd0;
  localparam logic [1:0] OP_CPH = 2'd1;
  localparam logic [1:0] OP_SWP = 2'd2;

  // An angle format without room for pi (sign + two integer bits) emits zero rotations.
  localparam logic signed [TOTAL_BITS-1:0] PI_S =
    (FRAC_BITS <= TOTAL_BITS - 3) ? TOTAL_BITS'(PI_FIXED) : '0;
  localparam logic [QW:0]   NQ       = (QW+1)'(NUM_QUBITS);
  localparam logic [QW:0]   NQ_HALF  = (QW+1)'(NUM_QUBITS / 2);
  localparam logic [QW-1:0] LAST_Q   = QW'(NUM_QUBITS - 1);
  localparam logic          HAS_SWP  = (NUM_QUBITS >= 2) ? 1'b1 : 1'b0;
  localparam logic [7:0]    SHIFT_LIM = 8'(TOTAL_BITS);

  state_t          state_r, state_s;
  logic [QW-1:0]   t_r, t_s, c_r, c_s, s_r, s_s;
  logic [QW:0]     t_inc_s, c_inc_s, s_inc_s, diff_s;
  logic [7:0]      shift_s;
  logic            hs_s, xfer_s, accept_s;

  logic                         valid_s, busy_s, done_s;
  logic [1:0]                   code_s;
  logic [QW-1:0]                ctrl_s, tgt_s;
  logic signed [TOTAL_BITS-1:0] theta_s;

  assign hs_s     = op_valid & op_ready;
  assign xfer_s   = hs_s & ~abort;
  assign accept_s = (state_r == S_IDLE) & start & ~abort;
  assign t_inc_s  = {1'b0, t_r} + {{QW{1'b0}}, 1'b1};
  assign c_inc_s  = {1'b0, c_r} + {{QW{1'b0}}, 1'b1};
  assign s_inc_s  = {1'b0, s_r} + {{QW{1'b0}}, 1'b1};

  // State and loop-counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      t_r     <= '0;
      c_r     <= '0;
      s_r     <= '0;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      c_r     <= c_s;
      s_r     <= s_s;
    end
  end

  // Next-state and counter advance; abort outranks a simultaneous handshake
  always_comb begin
    state_s = state_r;
    t_s     = t_r;
    c_s     = c_r;
    s_s     = s_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_HAD;
          t_s     = '0;
          c_s     = '0;
          s_s     = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HAD: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (hs_s) begin
          if (t_inc_s < NQ) begin
            state_s = S_CPH;
            c_s     = t_inc_s[QW-1:0];
          end else if (HAS_SWP) begin
            state_s = S_SWP;
            s_s     = '0;
          end else begin
            state_s = S_FIN;
          end
        end else begin
          state_s = S_HAD;
        end
      end
      S_CPH: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (hs_s) begin
          if (c_inc_s < NQ) begin
            c_s = c_inc_s[QW-1:0];
          end else begin
            t_s     = t_inc_s[QW-1:0];
            state_s = S_HAD;
          end
        end else begin
          state_s = S_CPH;
        end
      end
      S_SWP: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (hs_s) begin
          if (s_inc_s < NQ_HALF) begin
            s_s = s_inc_s[QW-1:0];
          end else begin
            state_s = S_FIN;
          end
        end else begin
          state_s = S_SWP;
        end
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Descriptor for the upcoming state; a stall keeps state_s, so outputs hold
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    code_s  = OP_HAD;
    ctrl_s  = '0;
    tgt_s   = '0;
    theta_s = '0;
    diff_s  = {1'b0, c_s} - {1'b0, t_s};
    shift_s = 8'(diff_s);
    case (state_s)
      S_HAD: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        code_s  = OP_HAD;
        ctrl_s  = t_s;
        tgt_s   = t_s;
      end
      S_CPH: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        code_s  = OP_CPH;
        ctrl_s  = c_s;
        tgt_s   = t_s;
        if (shift_s >= SHIFT_LIM) begin
          theta_s = '0;
        end else begin
          theta_s = PI_S >>> shift_s;
        end
      end
      S_SWP: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        code_s  = OP_SWP;
        ctrl_s  = s_s;
        tgt_s   = LAST_Q - s_s;
      end
      S_FIN:   done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // Registered outputs and running descriptor count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
      op_code  <= 2'd0;
      op_ctrl  <= '0;
      op_tgt   <= '0;
      op_theta <= '0;
      op_index <= '0;
    end else begin
      busy     <= busy_s;
      done     <= done_s;
      op_valid <= valid_s;
      op_code  <= code_s;
      op_ctrl  <= ctrl_s;
      op_tgt   <= tgt_s;
      op_theta <= theta_s;
      if (accept_s) begin
        op_index <= '0;
      end else if (xfer_s) begin
        op_index <= op_index + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        op_index <= op_index;
      end
    end
  end

endmodule

// File: tb/tb_qft_cphase_sequencer.sv
// Bench for qft_cphase_sequencer: reference gate list built from nested QFT loops,
// driven with steady, patterned and random backpressure plus abort/reset/restart cases.
module tb_qft_cphase_sequencer;
  localparam int N  = 4;
  localparam int PI = 25736;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, op_ready = 1'b0;
  logic        busy, done, op_valid;
  logic [1:0]  op_code, op_ctrl, op_tgt;
  logic [15:0] op_theta;
  logic [7:0]  op_index;

  logic        start1 = 1'b0, abort1 = 1'b0, op_ready1 = 1'b1;
  logic        busy1, done1, op_valid1;
  logic [1:0]  op_code1;
  logic [0:0]  op_ctrl1, op_tgt1;
  logic [15:0] op_theta1;
  logic [7:0]  op_index1;

  int checks = 0;
  int errors = 0;

  typedef struct {int code; int ctrl; int tgt; int theta;} desc_t;
  desc_t exp_q[$];

  qft_cphase_sequencer #(.NUM_QUBITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_ready(op_ready),
    .busy(busy), .done(done), .op_valid(op_valid), .op_code(op_code),
    .op_ctrl(op_ctrl), .op_tgt(op_tgt), .op_theta(op_theta), .op_index(op_index)
  );

  qft_cphase_sequencer #(.NUM_QUBITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .op_ready(op_ready1),
    .busy(busy1), .done(done1), .op_valid(op_valid1), .op_code(op_code1),
    .op_ctrl(op_ctrl1), .op_tgt(op_tgt1), .op_theta(op_theta1), .op_index(op_index1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference QFT order: per target a Hadamard then rotations, then mirror swaps
  function automatic void build(input int n);
    desc_t d;
    exp_q.delete();
    for (int t = 0; t < n; t++) begin
      d = '{0, t, t, 0};
      exp_q.push_back(d);
      for (int c = t + 1; c < n; c++) begin
        d = '{1, c, t, ((c - t) >= 16) ? 0 : PI / (1 << (c - t))};
        exp_q.push_back(d);
      end
    end
    for (int s = 0; s < n / 2; s++) begin
      d = '{2, s, n - 1 - s, 0};
      exp_q.push_back(d);
    end
  endfunction

  // mode 0: ready held high, 1: pattern 1,0,0,1, 2: random; restart_at pulses start there
  task automatic run_seq(input int mode, input int restart_at);
    int   idx;
    int   cyc;
    int   total;
    logic r;
    build(N);
    total = exp_q.size();
    @(negedge clk);
    start    = 1'b1;
    op_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 400) begin
      chk("valid", op_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("code", op_code, exp_q[idx].code);
      chk("ctrl", op_ctrl, exp_q[idx].ctrl);
      chk("tgt", op_tgt, exp_q[idx].tgt);
      chk("theta", op_theta, exp_q[idx].theta);
      chk("index", op_index, idx);
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = ($urandom_range(3, 0) != 0);
      endcase
      op_ready = r;
      start    = (idx == restart_at);
      @(negedge clk);
      cyc++;
      if (r) idx++;
    end
    start    = 1'b0;
    op_ready = 1'b0;
    chk("seq_complete", idx, total);
    chk("done_pulse", done, 1);
    chk("valid_after_last", op_valid, 0);
    chk("busy_after_last", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_valid", op_valid, 0);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_theta", op_theta, 0);
    chk("rst_index", op_index, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq(0, -1);
    run_seq(1, -1);

    // abort while CP(2,0) is stalled, with ready raised in the same cycle
    build(N);
    @(negedge clk);
    start    = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op_ready = 1'b0;
    chk("abort_pre_ctrl", op_ctrl, 2);
    chk("abort_pre_theta", op_theta, exp_q[2].theta);
    @(negedge clk);
    chk("abort_stall_ctrl", op_ctrl, 2);
    chk("abort_stall_index", op_index, 2);
    abort    = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    op_ready = 1'b0;
    chk("abort_valid", op_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_index", op_index, 2);
    @(negedge clk);
    chk("abort_no_done", done, 0);

    run_seq(0, -1);
    run_seq(0, 5);
    run_seq(2, -1);
    run_seq(2, 7);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_start_valid", op_valid, 0);
    chk("idle_abort_start_busy", busy, 0);
    @(negedge clk);
    chk("idle_abort_start_valid2", op_valid, 0);

    // asynchronous reset mid-CPH
    @(negedge clk);
    start    = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_ready = 1'b0;
    chk("prerst_valid", op_valid, 1);
    chk("prerst_code", op_code, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", op_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_code", op_code, 0);
    chk("async_rst_ctrl", op_ctrl, 0);
    chk("async_rst_tgt", op_tgt, 0);
    chk("async_rst_theta", op_theta, 0);
    chk("async_rst_index", op_index, 0);
    @(negedge clk);
    rst = 1'b0;
    run_seq(0, -1);

    // single-qubit register: one Hadamard, no swaps
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_valid", op_valid1, 1);
    chk("n1_code", op_code1, 0);
    chk("n1_ctrl", op_ctrl1, 0);
    chk("n1_tgt", op_tgt1, 0);
    chk("n1_theta", op_theta1, 0);
    chk("n1_index", op_index1, 0);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_valid_end", op_valid1, 0);
    chk("n1_busy_end", busy1, 0);
    @(negedge clk);
    chk("n1_done_one_cycle", done1, 0);
    chk("n1_no_swap", op_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qft_cphase_sequencer.md
Name: qft_cphase_sequencer

Overview:
Upstream control stage for the QFT datapath. On `start`, it walks the standard QFT gate order for NUM_QUBITS qubits and emits one gate descriptor per valid/ready handshake. Each descriptor carries an opcode, control and target qubit indices, and a fixed-point phase angle. The downstream stage uses the angle directly as `theta_angle` for the controlled-phase gate and the cos/sin LUT. Order: per target, a Hadamard followed by its controlled-phase rotations, then the final bit-reversal swaps.

Parameters:
NUM_QUBITS, 4, number of qubits in the register (1..16)
TOTAL_BITS, 16, fixed-point word width, matching `TOTAL_BITS
FRAC_BITS, 13, fractional bits of the angle format
PI_FIXED, 25736, pi in the angle format (round(pi*2^FRAC_BITS))
QW, $clog2(NUM_QUBITS) min 1, qubit-index width
IDX_W, 8, op_index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a sequence; sampled only in IDLE
abort  in  1  terminate the current sequence
op_ready  in  1  downstream accepts the current descriptor
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse after the last descriptor handshake
op_valid  out  1  descriptor valid
op_code  out  2  0=HADAMARD, 1=CPHASE, 2=SWAP, 3=reserved (never emitted)
op_ctrl  out  QW  control qubit index
op_tgt  out  QW  target qubit index
op_theta  out  TOTAL_BITS  signed phase angle, fixed point
op_index  out  IDX_W  running descriptor count, starting at 0

Behaviour:
- Reset (asynchronous): FSM enters IDLE. busy, done, op_valid, op_code, op_ctrl, op_tgt, op_theta and op_index are all 0.
- All outputs are registered.
- FSM states: IDLE, HAD, CPH, SWP, FIN. Internal counters: t (target), c (control), s (swap).
- Transitions:
  - IDLE: start=1 -> HAD with t=0. op_valid rises on the next edge (1-cycle start latency).
  - HAD: descriptor {code=0, ctrl=t, tgt=t, theta=0}. On handshake: if t+1<NUM_QUBITS -> CPH with c=t+1; else if NUM_QUBITS>=2 -> SWP with s=0; else -> FIN.
  - CPH: descriptor {code=1, ctrl=c, tgt=t, theta=PI_FIXED >>> (c-t)}, arithmetic shift, truncated. Shifts >= TOTAL_BITS yield 0. On handshake: if c+1<NUM_QUBITS, c++; else t++ -> HAD.
  - SWP: descriptor {code=2, ctrl=s, tgt=NUM_QUBITS-1-s, theta=0}. On handshake: if s+1<NUM_QUBITS/2, s++; else -> FIN.
  - FIN: done=1 for exactly one cycle, op_valid=0, busy=0. Next state IDLE.
- Handshake: a transfer occurs on a rising edge where op_valid && op_ready.
  - While op_valid && !op_ready, every op_* output holds stable.
  - The next descriptor appears in the cycle after a transfer. Back-to-back transfers are allowed with op_ready held high, giving a throughput of 1 descriptor per cycle.
- op_index increments on each transfer and clears to 0 on an accepted start.
- Total descriptors: NUM_QUBITS + NUM_QUBITS*(NUM_QUBITS-1)/2 + floor(NUM_QUBITS/2). For N=4 this is 12.
- start while busy: ignored, with no effect on the sequence.
- abort (any non-IDLE state): next edge -> IDLE, op_valid=0, busy=0, done not pulsed. abort has priority over a simultaneous handshake.
- abort and start together in IDLE: start is ignored.
- rst asserted mid-sequence: immediate return to reset values. Downstream must discard any partially consumed sequence.

Test Plan:
1. N=4, op_ready held 1, pulse start:
   - 12 consecutive descriptors starting the cycle after start.
   - Order: H0; CP(1,0,12868); CP(2,0,6434); CP(3,0,3217); H1; CP(2,1,12868); CP(3,1,6434); H2; CP(3,2,12868); H3; SWAP(0,3); SWAP(1,2).
   - done pulses 1 cycle after the SWAP(1,2) transfer; op_index runs 0..11.
2. Backpressure: op_ready toggles 1,0,0,1 repeatedly -> descriptor fields stay stable while stalled, no descriptor is skipped or duplicated, and the same 12-op order as scenario 1 results.
3. abort asserted while the CP(2,0) descriptor is stalled -> op_valid=0 and busy=0 on the next cycle, no done pulse. A following start restarts at H0 with op_index=0.
4. start pulsed again at descriptor 5 -> ignored; the sequence completes normally with 12 ops.
5. NUM_QUBITS=1 -> exactly one descriptor H0 (ctrl=0, tgt=0, theta=0), then done; no SWAP is emitted.
6. rst asserted for 1 cycle mid-CPH with op_valid=1 -> all outputs 0 immediately (asynchronous); state IDLE; the next start produces the full sequence.
